ddr_cmd_issuer: RTL and testbench

- Controller-side command issuer that drives the DDR chip model's command bus.
- Accepts one read/write request at a time over a valid/ready handshake and keeps a per-bank open-row table.
- Emits one-hot ACT / PR / RD / WR (and refresh) command pulses, with bank-group, bank, row and column addresses, honouring tRCD, tRP, tCL and burst timing.
- Sits between the host request logic and the chip model; its outputs connect directly to the chip's commands/bg/ba/row/column inputs.

---
 rtl/ddr_cmd_issuer.sv | 271 +++++++++++++++++++++++++++
 tb/tb_ddr_cmd_issuer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_cmd_issuer.sv
// DDR command issuer: one request at a time, per-bank open-row table, timed ACT/PR/RD/WR pulses.
// Define REFRESH_EN to add the periodic PRA/REF refresh sequence.
module ddr_cmd_issuer #(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 10,
  parameter int BL        = 8,
  parameter int TRCD      = 4,
  parameter int TRP       = 4,
  parameter int TCL       = 5,
  parameter int TREFI     = 1560,
  parameter int TRFC      = 52
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 halt,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [BGWIDTH:0]     req_bg,
  input  logic [BAWIDTH:0]     req_ba,
  input  logic [ADDRWIDTH-1:0] req_row,
  input  logic [COLWIDTH-1:0]  req_col,
  output logic                 rsp_valid,
  output logic [18:0]          commands,
  output logic [BGWIDTH:0]     bg,
  output logic [BAWIDTH:0]     ba,
  output logic [ADDRWIDTH-1:0] row,
  output logic [COLWIDTH-1:0]  column
);

  localparam int BANKGROUPS    = BGWIDTH ** 2;
  localparam int BANKSPERGROUP = BAWIDTH ** 2;
  localparam int NBANKS        = BANKGROUPS * BANKSPERGROUP;
  localparam int IDXW          = BGWIDTH + BAWIDTH;

  localparam int CMD_ACT = 0;
  localparam int CMD_PR  = 11;
  localparam int CMD_RD  = 13;
  localparam int CMD_WR  = 17;

  localparam logic [15:0] TRCD_M1 = 16'(TRCD - 1);
  localparam logic [15:0] TRP_M1  = 16'(TRP - 1);
  localparam logic [15:0] DATA_M1 = 16'(TCL + BL / 2 - 1);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_PRE       = 4'd1;
  localparam logic [3:0] S_WAIT_RP   = 4'd2;
  localparam logic [3:0] S_ACT       = 4'd3;
  localparam logic [3:0] S_WAIT_RCD  = 4'd4;
  localparam logic [3:0] S_CAS       = 4'd5;
  localparam logic [3:0] S_WAIT_DATA = 4'd6;
  localparam logic [3:0] S_RESP      = 4'd7;

  logic [3:0]           state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [18:0]          commands_q, commands_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 write_q, write_d;
  logic [BGWIDTH:0]     bg_q, bg_d;
  logic [BAWIDTH:0]     ba_q, ba_d;
  logic [ADDRWIDTH-1:0] row_q, row_d;
  logic [COLWIDTH-1:0]  col_q, col_d;
  logic [NBANKS-1:0]    tbl_valid_q, tbl_valid_d;
  logic [ADDRWIDTH-1:0] tbl_row_q [NBANKS];
  logic [ADDRWIDTH-1:0] tbl_row_d [NBANKS];
  logic [IDXW-1:0]      req_idx, cur_idx;
  logic                 refresh_pending;

`ifdef REFRESH_EN
  localparam int CMD_PRA = 12;
  localparam int CMD_REF = 15;
  localparam logic [15:0] TREFI_M1 = 16'(TREFI - 1);
  localparam logic [15:0] TRFC_M1  = 16'(TRFC - 1);
  localparam logic [3:0] S_REF_PRA     = 4'd8;
  localparam logic [3:0] S_REF_WAIT_RP = 4'd9;
  localparam logic [3:0] S_REF_CMD     = 4'd10;
  localparam logic [3:0] S_REF_WAIT_RFC = 4'd11;

  logic [15:0] ref_cnt_q, ref_cnt_d;
  logic        refresh_pending_q, refresh_pending_d;
  assign refresh_pending = refresh_pending_q;
`else
  logic unused_refresh_cfg;
  assign refresh_pending    = 1'b0;
  assign unused_refresh_cfg = (TREFI > 0) ^ (TRFC > 0);
`endif

  assign req_idx   = {req_bg[BGWIDTH-1:0], req_ba[BAWIDTH-1:0]};
  assign cur_idx   = {bg_q[BGWIDTH-1:0], ba_q[BAWIDTH-1:0]};
  assign req_ready = (state_q == S_IDLE) && !refresh_pending && !halt;
  assign commands  = commands_q;
  assign rsp_valid = rsp_valid_q;
  assign bg        = bg_q;
  assign ba        = ba_q;
  assign row       = row_q;
  assign column    = col_q;

  // Next-state, command and open-row table update; wait states issue the follow-on command on the cycle they expire
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    commands_d  = 19'd0;
    rsp_valid_d = 1'b0;
    write_d     = write_q;
    bg_d        = bg_q;
    ba_d        = ba_q;
    row_d       = row_q;
    col_d       = col_q;
    tbl_valid_d = tbl_valid_q;
    tbl_row_d   = tbl_row_q;
`ifdef REFRESH_EN
    ref_cnt_d         = ref_cnt_q;
    refresh_pending_d = refresh_pending_q;
`endif
    if (!halt) begin
      case (state_q)
        S_IDLE: begin
          if (refresh_pending) begin
`ifdef REFRESH_EN
            state_d = (|tbl_valid_q) ? S_REF_PRA : S_REF_CMD;
`else
            state_d = S_IDLE;
`endif
          end else if (req_valid) begin
            write_d = req_write;
            bg_d    = req_bg;
            ba_d    = req_ba;
            row_d   = req_row;
            col_d   = req_col;
            if (tbl_valid_q[req_idx] && (tbl_row_q[req_idx] == req_row)) begin
              state_d = S_CAS;
            end else if (tbl_valid_q[req_idx]) begin
              state_d = S_PRE;
            end else begin
              state_d = S_ACT;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_PRE: begin
          commands_d[CMD_PR]   = 1'b1;
          tbl_valid_d[cur_idx] = 1'b0;
          cnt_d                = TRP_M1;
          state_d              = S_WAIT_RP;
        end
        S_WAIT_RP, S_ACT: begin
          if ((state_q == S_ACT) || (cnt_q == 16'd0)) begin
            commands_d[CMD_ACT]  = 1'b1;
            tbl_valid_d[cur_idx] = 1'b1;
            tbl_row_d[cur_idx]   = row_q;
            cnt_d                = TRCD_M1;
            state_d              = S_WAIT_RCD;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        S_WAIT_RCD, S_CAS: begin
          if ((state_q == S_CAS) || (cnt_q == 16'd0)) begin
            if (write_q) begin
              commands_d[CMD_WR] = 1'b1;
            end else begin
              commands_d[CMD_RD] = 1'b1;
            end
            cnt_d   = DATA_M1;
            state_d = S_WAIT_DATA;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        S_WAIT_DATA: begin
          if (cnt_q == 16'd0) begin
            state_d = S_RESP;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        S_RESP: begin
          rsp_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
`ifdef REFRESH_EN
        S_REF_PRA: begin
          commands_d[CMD_PRA] = 1'b1;
          tbl_valid_d         = {NBANKS{1'b0}};
          cnt_d               = TRP_M1;
          state_d             = S_REF_WAIT_RP;
        end
        S_REF_WAIT_RP, S_REF_CMD: begin
          if ((state_q == S_REF_CMD) || (cnt_q == 16'd0)) begin
            commands_d[CMD_REF] = 1'b1;
            cnt_d               = TRFC_M1;
            state_d             = S_REF_WAIT_RFC;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        S_REF_WAIT_RFC: begin
          if (cnt_q == 16'd0) begin
            refresh_pending_d = 1'b0;
            state_d           = S_IDLE;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
`endif
        default: begin
          state_d = S_IDLE;
        end
      endcase
`ifdef REFRESH_EN
      // A new refresh tick wins over the clear from a finishing refresh
      if (ref_cnt_q == 16'd0) begin
        ref_cnt_d         = TREFI_M1;
        refresh_pending_d = 1'b1;
      end else begin
        ref_cnt_d = ref_cnt_q - 16'd1;
      end
`endif
    end else begin
      state_d = state_q;
    end
  end

  // Controller state, command/address outputs and open-row table
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 16'd0;
      commands_q  <= 19'd0;
      rsp_valid_q <= 1'b0;
      write_q     <= 1'b0;
      bg_q        <= {(BGWIDTH + 1){1'b0}};
      ba_q        <= {(BAWIDTH + 1){1'b0}};
      row_q       <= {ADDRWIDTH{1'b0}};
      col_q       <= {COLWIDTH{1'b0}};
      tbl_valid_q <= {NBANKS{1'b0}};
      for (int i = 0; i < NBANKS; i++) begin
        tbl_row_q[i] <= {ADDRWIDTH{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      commands_q  <= commands_d;
      rsp_valid_q <= rsp_valid_d;
      write_q     <= write_d;
      bg_q        <= bg_d;
      ba_q        <= ba_d;
      row_q       <= row_d;
      col_q       <= col_d;
      tbl_valid_q <= tbl_valid_d;
      tbl_row_q   <= tbl_row_d;
    end
  end

`ifdef REFRESH_EN
  // Refresh interval counter and pending flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ref_cnt_q         <= TREFI_M1;
      refresh_pending_q <= 1'b0;
    end else begin
      ref_cnt_q         <= ref_cnt_d;
      refresh_pending_q <= refresh_pending_d;
    end
  end
`endif

endmodule

// File: tb/tb_ddr_cmd_issuer.sv
// Scoreboard bench for ddr_cmd_issuer: expected command/response events are queued with their cycle at acceptance.
module tb_ddr_cmd_issuer;

  localparam int BGW = 2;
  localparam int BAW = 2;
  localparam int AW  = 17;
  localparam int CW  = 10;
  localparam int BL  = 8;
  localparam int TRCD = 4;
  localparam int TRP  = 4;
  localparam int TCL  = 5;
  localparam int TRFC = 52;
`ifdef REFRESH_EN
  localparam int TREFI = 20;
`else
  localparam int TREFI = 1560;
`endif
  localparam int DATA = TCL + BL / 2;
  localparam int NB   = 16;

  localparam int EV_ACT = 0;
  localparam int EV_PR  = 11;
  localparam int EV_PRA = 12;
  localparam int EV_RD  = 13;
  localparam int EV_REF = 15;
  localparam int EV_WR  = 17;
  localparam int EV_RSP = 19;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          halt = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [BGW:0]  req_bg = '0;
  logic [BAW:0]  req_ba = '0;
  logic [AW-1:0] req_row = '0;
  logic [CW-1:0] req_col = '0;
  logic          rsp_valid;
  logic [18:0]   commands;
  logic [BGW:0]  bg;
  logic [BAW:0]  ba;
  logic [AW-1:0] row;
  logic [CW-1:0] column;

  ddr_cmd_issuer #(
    .BGWIDTH(BGW), .BAWIDTH(BAW), .ADDRWIDTH(AW), .COLWIDTH(CW), .BL(BL),
    .TRCD(TRCD), .TRP(TRP), .TCL(TCL), .TREFI(TREFI), .TRFC(TRFC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .halt(halt),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
    .rsp_valid(rsp_valid), .commands(commands),
    .bg(bg), .ba(ba), .row(row), .column(column)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [19:0]   ev;
    logic          chk_addr;
    logic [BGW:0]  bg;
    logic [BAW:0]  ba;
    logic [AW-1:0] row;
    logic [CW-1:0] col;
  } exp_t;

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  logic [NB-1:0] m_valid = '0;
  logic [AW-1:0] m_row [NB];
  exp_t          mon_e;
  logic [19:0]   mon_ev;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_ev(input int c, input int b, input logic chk, input logic [BGW:0] b_g,
                         input logic [BAW:0] b_a, input logic [AW-1:0] r, input logic [CW-1:0] cl);
    exp_t e;
    e.cyc = c;
    e.ev = 20'd0;
    e.ev[b] = 1'b1;
    e.chk_addr = chk;
    e.bg = b_g;
    e.ba = b_a;
    e.row = r;
    e.col = cl;
    sb.push_back(e);
  endtask

  // Called at a negedge; presents the request, predicts its events from the bench's own bank model.
  task automatic send(input logic wr, input logic [BGW:0] b_g, input logic [BAW:0] b_a,
                      input logic [AW-1:0] r, input logic [CW-1:0] cl, input int stall);
    int k;
    int n;
    int c;
    logic [3:0] idx;
    req_valid = 1'b1;
    req_write = wr;
    req_bg = b_g;
    req_ba = b_a;
    req_row = r;
    req_col = cl;
    k = 0;
    while (!req_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      check_eq("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
    end else begin
      n = cyc + 1;
      idx = {b_g[1:0], b_a[1:0]};
      if (m_valid[idx] && m_row[idx] == r) begin
        c = n + 1;
      end else if (m_valid[idx]) begin
        push_ev(n + 1, EV_PR, 1'b1, b_g, b_a, r, cl);
        push_ev(n + 1 + TRP, EV_ACT, 1'b1, b_g, b_a, r, cl);
        c = n + 1 + TRP + TRCD;
      end else begin
        push_ev(n + 1, EV_ACT, 1'b1, b_g, b_a, r, cl);
        c = n + 1 + TRCD;
      end
      c = c + stall;
      push_ev(c, wr ? EV_WR : EV_RD, 1'b1, b_g, b_a, r, cl);
      push_ev(c + DATA + 1, EV_RSP, 1'b1, b_g, b_a, r, cl);
      m_valid[idx] = 1'b1;
      m_row[idx] = r;
      @(posedge clk);
      #1 req_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      check_eq("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  // Every nonzero command/response cycle must match the next queued expectation
  always @(negedge clk) begin
    if (reset_n) begin
      mon_ev = {rsp_valid, commands};
      if (mon_ev != 20'd0) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_ev", mon_ev, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check_eq("ev_kind", mon_ev, mon_e.ev);
          check_eq("ev_cycle", cyc, mon_e.cyc);
          if (mon_e.chk_addr) begin
            check_eq("ev_bg", bg, mon_e.bg);
            check_eq("ev_ba", ba, mon_e.ba);
            check_eq("ev_row", row, mon_e.row);
            check_eq("ev_col", column, mon_e.col);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_commands", commands, 32'd0);
    check_eq("rst_rsp_valid", rsp_valid, 32'd0);
    check_eq("rst_addr", {bg, ba, row, column}, 32'd0);
    reset_n = 1'b1;
    #1 check_eq("rst_ready", req_ready, 32'd1);
    r0 = cyc;
`ifdef REFRESH_EN
    // Open one bank, then collide a request with the refresh tick
    send(1'b0, 3'd0, 3'd1, 17'h5, 10'h0, 0);
    wait_done();
    while (cyc < r0 + 20) @(negedge clk);
    check_eq("ref_ready_low", req_ready, 32'd0);
    push_ev(r0 + 22, EV_PRA, 1'b0, 3'd0, 3'd0, 17'h0, 10'h0);
    push_ev(r0 + 22 + TRP, EV_REF, 1'b0, 3'd0, 3'd0, 17'h0, 10'h0);
    m_valid = '0;
    send(1'b0, 3'd0, 3'd2, 17'h7, 10'h3, 0);
    wait_done();
`else
    // Closed, hit, conflict, then hit on the newly opened row
    @(negedge clk); send(1'b0, 3'd1, 3'd2, 17'h100, 10'h10, 0); wait_done();
    @(negedge clk); send(1'b1, 3'd1, 3'd2, 17'h100, 10'h10, 0); wait_done();
    @(negedge clk); send(1'b0, 3'd1, 3'd2, 17'h200, 10'h20, 0); wait_done();
    @(negedge clk); send(1'b0, 3'd1, 3'd2, 17'h200, 10'h21, 0); wait_done();

    @(negedge clk);
    halt = 1'b1;
    #1 check_eq("halt_idle_ready", req_ready, 32'd0);
    @(negedge clk);
    halt = 1'b0;

    // halt for 3 cycles inside WAIT_RCD
    @(negedge clk); send(1'b0, 3'd0, 3'd3, 17'h55, 10'h7, 3);
    repeat (3) @(negedge clk);
    halt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("halt_commands", commands, 32'd0);
      check_eq("halt_ready", req_ready, 32'd0);
    end
    halt = 1'b0;
    wait_done();

    // Extreme addresses, then conflict in the same bank
    @(negedge clk); send(1'b1, 3'd3, 3'd0, 17'h1FFFF, 10'h3FF, 0); wait_done();
    @(negedge clk); send(1'b0, 3'd3, 3'd0, 17'h0, 10'h0, 0); wait_done();

    // Reset in WAIT_DATA drops the response and closes every bank
    @(negedge clk); send(1'b0, 3'd2, 3'd1, 17'h33, 10'h5, 0); wait_done();
    @(negedge clk); send(1'b0, 3'd2, 3'd1, 17'h33, 10'h5, 0);
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_eq("midrst_commands", commands, 32'd0);
    check_eq("midrst_rsp", rsp_valid, 32'd0);
    check_eq("midrst_bg", bg, 32'd0);
    check_eq("midrst_ba", ba, 32'd0);
    check_eq("midrst_row", row, 32'd0);
    check_eq("midrst_col", column, 32'd0);
    sb.delete();
    m_valid = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    send(1'b0, 3'd2, 3'd1, 17'h33, 10'h5, 0); wait_done();
`endif
    check_eq("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
